// File: rtl/sram_16x8.sv
// Single-port 16x8 synchronous RAM with registered, read-first output.
// A synchronous active-low reset clears the whole array and the output register.
module sram_16x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The read samples mem before the same-edge write lands, giving read-first behaviour
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            dout <= '0;
        end else begin
            if (we) begin
                mem[addr] <= din;
            end
            if (re) begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_sram_16x8.sv
// Self-checking bench for sram_16x8: a reference model pushes the expected dout
// for every driven cycle into a queue, and each test pops and compares it.
module tb_sram_16x8;

    logic       clk;
    logic       rst;
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    logic [7:0] model [16];
    logic [7:0] exp_dout;
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;
    int         checks;
    int         failures;

    sram_16x8 #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .re  (re),
        .addr(addr),
        .din (din),
        .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus at the falling edge, update the model and push
    // the dout value expected after the next rising edge; returns at the next falling edge.
    task automatic drive(input logic r, input logic w, input logic rd,
                         input logic [3:0] a, input logic [7:0] d);
        rst  = r;
        we   = w;
        re   = rd;
        addr = a;
        din  = d;
        if (!r) begin
            for (int i = 0; i < 16; i++) model[i] = 8'h00;
            exp_dout = 8'h00;
        end else begin
            if (rd) exp_dout = model[a];
            if (w) model[a] = d;
        end
        exp_q.push_back(exp_dout);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (dout !== exp_v) begin
                failures++;
                $display("FAIL reset_initial: dout=%h expected=%h", dout, exp_v);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 4'd5, 8'hFF);
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (dout !== exp_v) begin
            failures++;
            $display("FAIL reset_write_hold: dout=%h expected=%h", dout, exp_v);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd5, 8'h00);
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (dout !== 8'h00 || dout !== exp_v) begin
            failures++;
            $display("FAIL reset_pulse_dout: dout=%h expected=00", dout);
        end
        drive(1'b1, 1'b0, 1'b1, 4'd5, 8'h00);
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (dout !== 8'h00 || dout !== exp_v) begin
            failures++;
            $display("FAIL reset_clear_read: dout=%h expected=00", dout);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 1'b1, 1'b0, 4'd12, 8'h1E);
        void'(exp_q.pop_front());
        drive(1'b1, 1'b0, 1'b1, 4'd12, 8'h00);
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (dout !== 8'h1E || dout !== exp_v) begin
            failures++;
            $display("FAIL single_read: dout=%h expected=1e", dout);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'(i), 8'h00);
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (dout !== 8'h1E || dout !== exp_v) begin
                failures++;
                $display("FAIL single_hold: cycle=%0d dout=%h expected=1e", i, dout);
            end
        end
    endtask

    task automatic test_sweep();
        for (int l = 0; l < 16; l++) begin
            drive(1'b1, 1'b1, 1'b0, 4'(l), 8'(l + 1));
            void'(exp_q.pop_front());
        end
        for (int l = 0; l < 16; l++) begin
            drive(1'b1, 1'b0, 1'b1, 4'(l), 8'h00);
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (dout !== 8'(l + 1) || dout !== exp_v) begin
                failures++;
                $display("FAIL sweep_read: addr=%0d dout=%h expected=%h", l, dout, 8'(l + 1));
            end
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 1'b1, 1'b1, 4'd3, 8'hA5);
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (dout !== 8'h04 || dout !== exp_v) begin
            failures++;
            $display("FAIL simul_read_first: dout=%h expected=04", dout);
        end
        drive(1'b1, 1'b0, 1'b1, 4'd3, 8'h00);
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (dout !== 8'hA5 || dout !== exp_v) begin
            failures++;
            $display("FAIL simul_new_data: dout=%h expected=a5", dout);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 1'b0, 4'd7, 8'h5A);
        void'(exp_q.pop_front());
        drive(1'b1, 1'b0, 1'b1, 4'd7, 8'h00);
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (dout !== 8'h5A || dout !== exp_v) begin
            failures++;
            $display("FAIL back_to_back: dout=%h expected=5a", dout);
        end
    endtask

    task automatic test_idle_hold();
        // Address 15 still holds 16 from the sweep
        drive(1'b1, 1'b0, 1'b1, 4'd15, 8'h00);
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (dout !== 8'h10 || dout !== exp_v) begin
            failures++;
            $display("FAIL idle_setup: dout=%h expected=10", dout);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'(i * 3 + 1), 8'hEE);
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (dout !== 8'h10 || dout !== exp_v) begin
                failures++;
                $display("FAIL idle_hold: cycle=%0d dout=%h expected=10", i, dout);
            end
        end
        for (int l = 0; l < 16; l++) begin
            drive(1'b1, 1'b0, 1'b1, 4'(l), 8'h00);
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (dout !== exp_v) begin
                failures++;
                $display("FAIL idle_mem_intact: addr=%0d dout=%h expected=%h", l, dout, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int l = 0; l < 9; l++) begin
            drive(1'b1, 1'b1, 1'b0, 4'(l), 8'(8'h30 + l));
            void'(exp_q.pop_front());
        end
        drive(1'b0, 1'b1, 1'b0, 4'd9, 8'h77);
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (dout !== 8'h00 || dout !== exp_v) begin
            failures++;
            $display("FAIL reset_mid_dout: dout=%h expected=00", dout);
        end
        for (int l = 0; l < 16; l++) begin
            drive(1'b1, 1'b0, 1'b1, 4'(l), 8'h00);
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (dout !== 8'h00 || dout !== exp_v) begin
                failures++;
                $display("FAIL reset_mid_read: addr=%0d dout=%h expected=00", l, dout);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_dout = 8'h00;
        rst  = 1'b0;
        we   = 1'b0;
        re   = 1'b0;
        addr = 4'd0;
        din  = 8'h00;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        @(negedge clk);

        test_reset();
        test_single();
        test_sweep();
        test_simultaneous();
        test_back_to_back();
        test_idle_hold();
        test_reset_mid();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
